multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
Main sequencer for the multi-cycle build of the processor. It replaces single-cycle opcode decoding with a Moore state machine that steps one shared ALU and one shared instruction/data memory through fetch, decode, execute, memory and write-back. It sits beside the datapath and drives every mux-select and write-enable from the instruction register (IR) opcode. It stalls on a memory-ready handshake.

Parameters:
OPC_W, 6, opcode field width (instruction[31:26])
ST_W, 4, state register width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
instruction  input  32  current IR contents; only [31:26] used, sampled in DECODE
mem_ready  input  1  memory completes the current read/write this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load qualified by ALU zero (beq)
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  IR load enable
MemToReg  output  1  write-back data: 0 = ALUOut, 1 = MDR
RegDst  output  1  destination: 0 = rt, 1 = rd
RegWrite  output  1  register file write enable
ALUSrcA  output  1  0 = PC, 1 = rs
ALUSrcB  output  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
ALUOp  output  2  00 = add, 01 = sub, 10 = funct-decoded
PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
instr_done  output  1  one-cycle pulse in the last cycle of each instruction
illegal_op  output  1  one-cycle pulse on an unsupported opcode
state  output  4  current state, for debug

Behaviour:
- Reset: synchronous. While reset=1, state <= FETCH and all outputs are forced to 0. The first FETCH output appears in the cycle after reset deasserts. If reset asserts mid-instruction, that instruction is abandoned with no write.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite are asserted only when mem_ready=1.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute). Next state by opcode:
  - lw/sw/addi -> MEM_ADDR
  - R -> EXECUTE
  - beq -> BRANCH
  - j -> JUMP
  - any other -> ILLEGAL
- MEM_ADDR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: lw -> MEM_READ, sw -> MEM_WRITE, addi -> ADDI_WB.
- MEM_READ(3): MemRead=1, IorD=1. Holds until mem_ready, then -> MEM_WB.
- MEM_WB(4): RegWrite=1, MemToReg=1, RegDst=0, instr_done=1 -> FETCH.
- MEM_WRITE(5): MemWrite=1, IorD=1. Holds until mem_ready. In the cycle mem_ready=1: instr_done=1 and next state is FETCH.
- EXECUTE(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> R_WB.
- R_WB(7): RegWrite=1, RegDst=1, MemToReg=0, instr_done=1 -> FETCH.
- BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1 -> FETCH.
- JUMP(9): PCWrite=1, PCSource=10, instr_done=1 -> FETCH.
- ADDI_WB(10): RegWrite=1, RegDst=0, MemToReg=0, instr_done=1 -> FETCH.
- ILLEGAL(11): illegal_op=1, instr_done=1, no writes -> FETCH (the instruction is treated as a NOP).
- Unused state encodings 12-15 go to FETCH with all outputs 0.
- Latency with zero wait (mem_ready always 1), counted from FETCH entry through the instr_done cycle:
  - beq, j, illegal: 3
  - R, sw, addi: 4
  - lw: 5
  - Each wait cycle adds 1.
- mem_ready is ignored outside FETCH, MEM_READ and MEM_WRITE.
- Outputs are decoded from the registered state. The only Mealy terms are the mem_ready qualifiers on IRWrite, PCWrite (FETCH) and instr_done (MEM_WRITE).
- At most one of MemRead and MemWrite is asserted in any cycle. RegWrite is never asserted in the same cycle as MemWrite.

Decomposition:
- Shared package holds:
  - opcode localparams: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - ALUOp encodings: ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
  - ALUSrcB and PCSource encodings
  - state encodings S_FETCH..S_ILLEGAL
- Sub-module: none required. Optional `mcfsm_output_decode` as a purely combinational state-to-controls table.

Test Plan:
- reset=1 for 2 cycles with mem_ready=1 -> all outputs 0 and state=0 during reset. First cycle after release: MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
- R-type (instruction=32'h012A4020), mem_ready=1 -> states 0,1,6,7. RegWrite=1 and RegDst=1 only in the 4th cycle, with instr_done=1 in that cycle.
- lw (32'h8D090004), mem_ready low for 2 cycles in MEM_READ -> states 0,1,2,3,3,3,4. MemToReg=1 and RegWrite=1 in the final cycle; total 7 cycles.
- sw (32'hAD090008), mem_ready held 0 for 3 cycles in FETCH -> IRWrite stays 0 until mem_ready=1. MemWrite=1, IorD=1 in state 5; instr_done pulses once.
- beq (32'h11090003) then j (32'h08000010) -> beq: PCWriteCond=1, ALUOp=01, PCSource=01 in the 3rd cycle. j: PCWrite=1, PCSource=10 in the 3rd cycle.
- opcode 6'b111111, then reset asserted while in MEM_READ of a following lw -> illegal_op pulses for 1 cycle with no RegWrite or MemWrite. The reset returns the FSM to state 0 with no RegWrite for the lw.

Source files
------------

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multi-cycle control sequencer: field widths,
// opcode values, mux-select encodings, state encodings and the control bundle.
package multicycle_control_fsm_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OPC_W   = 6;
    localparam int unsigned ST_W    = 4;

    // Supported opcodes (instruction[31:26])
    localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPC_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;

    // ALU operation select
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B-operand select
    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [ST_W-1:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_WB   = 4'd10,
        S_ILLEGAL   = 4'd11
    } state_e;

    // Full set of datapath controls produced each cycle
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control/datapath bundle between the sequencer and the datapath.
// master (sequencer): receives instruction, mem_ready; drives all controls + state.
// slave  (datapath/bench): drives instruction, mem_ready; observes controls.
interface multicycle_control_fsm_if;
    import multicycle_control_fsm_pkg::*;

    logic [INSTR_W-1:0] instruction;
    logic               mem_ready;
    logic               PCWrite;
    logic               PCWriteCond;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               IRWrite;
    logic               MemToReg;
    logic               RegDst;
    logic               RegWrite;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         ALUOp;
    logic [1:0]         PCSource;
    logic               instr_done;
    logic               illegal_op;
    logic [ST_W-1:0]    state;

    modport master (
        input  instruction, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, instr_done, illegal_op, state
    );

    modport slave (
        output instruction, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, instr_done, illegal_op, state
    );

endinterface

// File: rtl/multicycle_control_fsm_output_decode.sv
// Purely combinational state-to-controls table.
// Ports: state_i (current state), mem_ready_i (memory handshake),
//        ctrl_o (control bundle for that state).
module multicycle_control_fsm_output_decode
    import multicycle_control_fsm_pkg::*;
(
    input  state_e state_i,
    input  logic   mem_ready_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.iord      = 1'b0;
                ctrl_o.alu_src_a = 1'b0;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                // IR and PC only load once the fetch read has completed
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                // Branch target precompute: PC + (imm << 2)
                ctrl_o.alu_src_a = 1'b0;
                ctrl_o.alu_src_b = SRCB_IMM_SL2;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_dst    = 1'b0;
                ctrl_o.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.iord       = 1'b1;
                ctrl_o.instr_done = mem_ready_i;
            end
            S_EXECUTE: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_RT;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.mem_to_reg = 1'b0;
                ctrl_o.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_RT;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
                ctrl_o.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_source  = PCSRC_JUMP;
                ctrl_o.instr_done = 1'b1;
            end
            S_ADDI_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b0;
                ctrl_o.mem_to_reg = 1'b0;
                ctrl_o.instr_done = 1'b1;
            end
            S_ILLEGAL: begin
                ctrl_o.illegal_op = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle processor sequencer: Moore FSM stepping fetch/decode/execute/
// memory/write-back, stalling on mem_ready.
// Ports: clk, reset (synchronous, active-high), bus (master modport: IR and
//        mem_ready in; all datapath controls, instr_done, illegal_op, state out).
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    multicycle_control_fsm_if.master  bus
);

    state_e             state_q, state_d;
    logic [OPC_W-1:0]   opcode_q, opcode_d;
    logic [OPC_W-1:0]   opcode_in;
    ctrl_t              ctrl;
    ctrl_t              ctrl_out;
    logic               unused_instr_bits;

    assign opcode_in         = bus.instruction[INSTR_W-1 -: OPC_W];
    assign unused_instr_bits = ^bus.instruction[INSTR_W-OPC_W-1:0];

    // State and opcode registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    // Next-state logic; opcode is captured in DECODE for the MEM_ADDR split
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        case (state_q)
            S_FETCH: begin
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                opcode_d = opcode_in;
                case (opcode_in)
                    OP_LW, OP_SW, OP_ADDI: state_d = S_MEM_ADDR;
                    OP_RTYPE:              state_d = S_EXECUTE;
                    OP_BEQ:                state_d = S_BRANCH;
                    OP_J:                  state_d = S_JUMP;
                    default:               state_d = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: begin
                case (opcode_q)
                    OP_LW:   state_d = S_MEM_READ;
                    OP_SW:   state_d = S_MEM_WRITE;
                    OP_ADDI: state_d = S_ADDI_WB;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM_READ: begin
                if (bus.mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WRITE: begin
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXECUTE:  state_d = S_R_WB;
            S_MEM_WB,
            S_R_WB,
            S_BRANCH,
            S_JUMP,
            S_ADDI_WB,
            S_ILLEGAL:  state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    multicycle_control_fsm_output_decode u_decode (
        .state_i     (state_q),
        .mem_ready_i (bus.mem_ready),
        .ctrl_o      (ctrl)
    );

    // Reset blanks every output in the same cycle it is asserted
    always_comb begin
        ctrl_out = ctrl;
        if (reset) ctrl_out = '0;
    end

    assign bus.PCWrite     = ctrl_out.pc_write;
    assign bus.PCWriteCond = ctrl_out.pc_write_cond;
    assign bus.IorD        = ctrl_out.iord;
    assign bus.MemRead     = ctrl_out.mem_read;
    assign bus.MemWrite    = ctrl_out.mem_write;
    assign bus.IRWrite     = ctrl_out.ir_write;
    assign bus.MemToReg    = ctrl_out.mem_to_reg;
    assign bus.RegDst      = ctrl_out.reg_dst;
    assign bus.RegWrite    = ctrl_out.reg_write;
    assign bus.ALUSrcA     = ctrl_out.alu_src_a;
    assign bus.ALUSrcB     = ctrl_out.alu_src_b;
    assign bus.ALUOp       = ctrl_out.alu_op;
    assign bus.PCSource    = ctrl_out.pc_source;
    assign bus.instr_done  = ctrl_out.instr_done;
    assign bus.illegal_op  = ctrl_out.illegal_op;
    assign bus.state       = reset ? {ST_W{1'b0}} : ST_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: directed scenarios followed by
// randomized instructions and mem_ready, checked against a behavioural model.
module tb_multicycle_control_fsm;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;
    int   path[$];

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic logic [17:0] get_obs();
        return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.IRWrite, bus.MemToReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.instr_done, bus.illegal_op};
    endfunction

    // Control values the datapath should see in each step of an instruction
    function automatic logic [17:0] exp_ctrl(input int st, input bit mr);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, done, ill;
        logic [1:0] srcb, aluop, pcsrc;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, done, ill} = '0;
        srcb = 2'b00; aluop = 2'b00; pcsrc = 2'b00;
        case (st)
            0:  begin mrd = 1'b1; srcb = 2'b01; irw = mr; pcw = mr; end
            1:  srcb = 2'b11;
            2:  begin srca = 1'b1; srcb = 2'b10; end
            3:  begin mrd = 1'b1; iord = 1'b1; end
            4:  begin rw = 1'b1; m2r = 1'b1; done = 1'b1; end
            5:  begin mwr = 1'b1; iord = 1'b1; done = mr; end
            6:  begin srca = 1'b1; aluop = 2'b10; end
            7:  begin rw = 1'b1; rdst = 1'b1; done = 1'b1; end
            8:  begin srca = 1'b1; aluop = 2'b01; pcwc = 1'b1; pcsrc = 2'b01; done = 1'b1; end
            9:  begin pcw = 1'b1; pcsrc = 2'b10; done = 1'b1; end
            10: begin rw = 1'b1; done = 1'b1; end
            11: begin ill = 1'b1; done = 1'b1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aluop, pcsrc, done, ill};
    endfunction

    // Zero-wait latency from FETCH entry through the instr_done cycle
    function automatic int base_latency(input logic [5:0] op);
        case (op)
            6'b100011:                       return 5;
            6'b000000, 6'b101011, 6'b001000: return 4;
            default:                         return 3;
        endcase
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    endfunction

    // Step sequence an instruction walks through
    task automatic build_path(input logic [5:0] op);
        path.delete();
        path.push_back(0);
        path.push_back(1);
        case (op)
            6'b000000: begin path.push_back(6); path.push_back(7); end
            6'b100011: begin path.push_back(2); path.push_back(3); path.push_back(4); end
            6'b101011: begin path.push_back(2); path.push_back(5); end
            6'b000100: path.push_back(8);
            6'b000010: path.push_back(9);
            6'b001000: begin path.push_back(2); path.push_back(10); end
            default:   path.push_back(11);
        endcase
    endtask

    // Runs one instruction starting from FETCH; stops early at abort_st if reached
    task automatic run_instr(input logic [31:0] ins, input bit rnd, input int fetch_wait,
                             input int mem_wait, input int abort_st);
        logic [5:0] op;
        int idx, cycles, waits, fw, mw, done_cnt, ill_cnt, cur;
        bit mr, aborted;
        op = ins[31:26];
        bus.instruction = ins;
        build_path(op);
        idx = 0; cycles = 0; waits = 0; fw = 0; mw = 0;
        done_cnt = 0; ill_cnt = 0; aborted = 1'b0;
        while (idx < path.size()) begin
            @(negedge clk);
            cur = path[idx];
            if (rnd)
                mr = ($urandom_range(0, 2) != 0);
            else if (cur == 0)
                mr = (fw >= fetch_wait);
            else if (cur == 3 || cur == 5)
                mr = (mw >= mem_wait);
            else
                mr = 1'($urandom_range(0, 1));
            bus.mem_ready = mr;
            #1;
            chk($sformatf("state op=%b step=%0d", op, cycles), 32'(bus.state), 32'(cur));
            chk($sformatf("ctrl op=%b state=%0d mr=%0b", op, cur, mr),
                32'(get_obs()), 32'(exp_ctrl(cur, mr)));
            done_cnt += int'(bus.instr_done);
            ill_cnt  += int'(bus.illegal_op);
            cycles++;
            if (cur == abort_st) begin
                aborted = 1'b1;
                break;
            end
            if ((cur == 0 || cur == 3 || cur == 5) && !mr) begin
                waits++;
                if (cur == 0) fw++; else mw++;
            end else begin
                idx++;
            end
            if (cycles > 100) begin
                chk("timeout_cycles", 32'(cycles), 32'd100);
                break;
            end
        end
        if (!aborted) begin
            chk($sformatf("latency op=%b waits=%0d", op, waits), 32'(cycles),
                32'(base_latency(op) + waits));
            chk($sformatf("instr_done_pulses op=%b", op), 32'(done_cnt), 32'd1);
            chk($sformatf("illegal_pulses op=%b", op), 32'(ill_cnt),
                is_legal(op) ? 32'd0 : 32'd1);
        end
    endtask

    initial begin
        logic [5:0] ops [6];
        logic [5:0] op;
        int k;
        n_pass = 0;
        n_total = 0;
        ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
        ops[3] = 6'b000100; ops[4] = 6'b000010; ops[5] = 6'b001000;

        reset = 1'b1;
        bus.mem_ready = 1'b1;
        bus.instruction = 32'h0;

        // Held in reset: everything reads zero
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            chk("reset_state", 32'(bus.state), 32'd0);
            chk("reset_ctrl", 32'(get_obs()), 32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b0;

        run_instr(32'h012A4020, 1'b0, 0, 0, -1);  // R-type
        run_instr(32'h8D090004, 1'b0, 0, 2, -1);  // lw, 2 waits in MEM_READ
        run_instr(32'hAD090008, 1'b0, 3, 0, -1);  // sw, 3 waits in FETCH
        run_instr(32'hAD090008, 1'b0, 0, 2, -1);  // sw, 2 waits in MEM_WRITE
        run_instr(32'h11090003, 1'b0, 0, 0, -1);  // beq
        run_instr(32'h08000010, 1'b0, 0, 0, -1);  // j
        run_instr(32'h21290005, 1'b0, 1, 0, -1);  // addi
        run_instr(32'hFC000000, 1'b0, 0, 0, -1);  // illegal opcode
        run_instr(32'h8D090004, 1'b0, 0, 5, 3);   // lw, abandoned in MEM_READ

        // Reset mid-instruction: outputs blank immediately, back to FETCH
        reset = 1'b1;
        #1;
        chk("midreset_state", 32'(bus.state), 32'd0);
        chk("midreset_ctrl", 32'(get_obs()), 32'd0);
        chk("midreset_regwrite", 32'(bus.RegWrite), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        run_instr(32'h21290001, 1'b0, 0, 0, -1);  // addi after the abort starts cleanly

        for (int n = 0; n < 60; n++) begin
            k = $urandom_range(0, 6);
            op = (k == 6) ? 6'($urandom) : ops[k];
            run_instr({op, 26'($urandom)}, 1'b1, 0, 0, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
